// File: rtl/qr_pkg.sv
// Shared types and constants for the 4x4 Givens QR engine.
package qr_pkg;

  localparam int unsigned QR_N   = 4;
  localparam int unsigned N_ROT  = 6;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;

  // Magnitude bits of an IEEE-754 single; sign is ignored so -0.0 counts as zero.
  localparam logic [DATA_W-1:0] FP_ZERO_MASK = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROBE = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } givens_seq_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] col;
  } rot_step_t;

  // True for +0.0 and -0.0 only; denormals are nonzero.
  function automatic logic fp_is_zero(input logic [DATA_W-1:0] x);
    return (x & FP_ZERO_MASK) == '0;
  endfunction

endpackage

// File: rtl/givens_schedule_rom.sv
// Fixed six-step elimination order for a 4x4 Givens QR: step -> (i, j, col).
module givens_schedule_rom
  import qr_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  output rot_step_t         entry
);

  // Combinational schedule lookup; unused codes fall back to step 0.
  always_comb begin
    entry = '{i: 2'd2, j: 2'd3, col: 2'd0};
    case (step)
      3'd0:    entry = '{i: 2'd2, j: 2'd3, col: 2'd0};
      3'd1:    entry = '{i: 2'd1, j: 2'd2, col: 2'd0};
      3'd2:    entry = '{i: 2'd0, j: 2'd1, col: 2'd0};
      3'd3:    entry = '{i: 2'd2, j: 2'd3, col: 2'd1};
      3'd4:    entry = '{i: 2'd1, j: 2'd2, col: 2'd1};
      3'd5:    entry = '{i: 2'd2, j: 2'd3, col: 2'd2};
      default: entry = '{i: 2'd2, j: 2'd3, col: 2'd0};
    endcase
  end

endmodule

// File: rtl/givens_sequencer.sv
// Control FSM for one 4x4 Givens QR run: probes each target, skips zeros,
// and issues the remaining rotations to the shared datapath one at a time.
module givens_sequencer #(
  parameter int unsigned N_ROT = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [qr_pkg::IDX_W-1:0]   probe_row,
  output logic [qr_pkg::IDX_W-1:0]   probe_col,
  input  logic [qr_pkg::DATA_W-1:0]  probe_data,
  output logic                       rot_valid,
  input  logic                       rot_ready,
  output logic [qr_pkg::IDX_W-1:0]   rot_i,
  output logic [qr_pkg::IDX_W-1:0]   rot_j,
  output logic [qr_pkg::IDX_W-1:0]   rot_col,
  input  logic                       rot_done,
  output logic [qr_pkg::CNT_W-1:0]   rot_count
);

  import qr_pkg::*;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_ROT - 1);

  givens_seq_state_t state_q, state_nxt;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  rot_step_t         sched_nxt;
  rot_step_t         sched_q;
  logic              busy_q, done_q, valid_q;

  // Schedule entry for the step being entered, so the registered i/j/col
  // line up with the registered state.
  givens_schedule_rom u_rom (
    .step  (step_nxt),
    .entry (sched_nxt)
  );

  // Next-state, step and rotation-count logic.
  always_comb begin
    state_nxt = state_q;
    step_nxt  = step_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = PROBE;
          step_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      PROBE: begin
        if (fp_is_zero(probe_data)) begin
          if (step_q == LAST_STEP) begin
            state_nxt = DONE;
          end else begin
            step_nxt = step_q + STEP_W'(1);
          end
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (rot_ready) begin
          state_nxt = WAIT;
          cnt_nxt   = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (rot_done) begin
          if (step_q == LAST_STEP) begin
            state_nxt = DONE;
          end else begin
            state_nxt = PROBE;
            step_nxt  = step_q + STEP_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      sched_q <= '{i: 2'd2, j: 2'd3, col: 2'd0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      step_q  <= step_nxt;
      cnt_q   <= cnt_nxt;
      sched_q <= sched_nxt;
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
      valid_q <= (state_nxt == ISSUE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rot_valid = valid_q;
  assign rot_count = cnt_q;
  assign rot_i     = sched_q.i;
  assign rot_j     = sched_q.j;
  assign rot_col   = sched_q.col;
  assign probe_row = sched_q.j;
  assign probe_col = sched_q.col;

endmodule

// File: tb/tb_givens_sequencer.sv
// Directed bench for givens_sequencer with a behavioural R matrix and datapath.
module tb_givens_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [1:0]  probe_row, probe_col;
  logic [31:0] probe_data;
  logic        rot_valid;
  logic        rot_ready = 1'b1;
  logic [1:0]  rot_i, rot_j, rot_col;
  logic        rot_done = 1'b0;
  logic [2:0]  rot_count;

  logic [31:0] mat [4][4];
  assign probe_data = mat[probe_row][probe_col];

  givens_sequencer #(.N_ROT(6)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .probe_row  (probe_row),
    .probe_col  (probe_col),
    .probe_data (probe_data),
    .rot_valid  (rot_valid),
    .rot_ready  (rot_ready),
    .rot_i      (rot_i),
    .rot_j      (rot_j),
    .rot_col    (rot_col),
    .rot_done   (rot_done),
    .rot_count  (rot_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  int cyc, done_cyc, done_cnt, nreq, stall_left;
  bit pend;
  logic [5:0] reqs [8];
  logic [5:0] exp_dense [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_dense();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mat[r][c] = 32'h3F80_0000 + 32'(r * 4 + c) * 32'h0001_0000;
  endtask

  // One run: pulse start, act as the datapath (ready high, done one cycle after
  // acceptance), optionally stall the third request and poke start while busy.
  task automatic run(input bit stall_en, input bit busy_starts, input int limit);
    cyc = 0; done_cyc = -1; done_cnt = 0; nreq = 0; pend = 0;
    stall_left = stall_en ? 5 : 0;
    for (int k = 0; k < 8; k++) reqs[k] = 6'h3F;
    start = 1'b1;
    while (cyc < limit) begin
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
      rot_done = pend;
      pend = 0;
      rot_ready = 1'b1;
      if (rot_valid) begin
        if (stall_en && nreq == 2) begin
          chk("bp_hold", {26'd0, rot_i, rot_j, rot_col}, 32'h04);
          if (stall_left > 0) begin
            rot_ready = 1'b0;
            stall_left--;
            if (stall_left == 3) rot_done = 1'b1;
          end else begin
            rot_done = 1'b1;
          end
        end
        if (rot_ready) begin
          if (nreq < 8) reqs[nreq] = {rot_i, rot_j, rot_col};
          nreq++;
          pend = 1;
        end
      end
      if (busy_starts && rot_done && nreq == 4) start = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy_starts) start = 1'b1;
      end
    end
    start = 1'b0;
    rot_done = 1'b0;
  endtask

  task automatic chk_dense_order(input string tag);
    for (int k = 0; k < 6; k++)
      chk(tag, {26'd0, reqs[k]}, {26'd0, exp_dense[k]});
  endtask

  initial begin
    exp_dense[0] = 6'b10_11_00;
    exp_dense[1] = 6'b01_10_00;
    exp_dense[2] = 6'b00_01_00;
    exp_dense[3] = 6'b10_11_01;
    exp_dense[4] = 6'b01_10_01;
    exp_dense[5] = 6'b10_11_10;
    fill_dense();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, rot_valid}, 32'd0);
    chk("rst_count", {29'd0, rot_count}, 32'd0);
    chk("rst_step", {26'd0, rot_i, rot_j, rot_col}, 32'b10_11_00);
    chk("rst_probe", {28'd0, probe_row, probe_col}, 32'b11_00);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Dense run
    run(1'b0, 1'b0, 24);
    chk("dense_nreq", 32'(nreq), 32'd6);
    chk_dense_order("dense_order");
    chk("dense_done_cyc", 32'(done_cyc), 32'd19);
    chk("dense_done_cnt", 32'(done_cnt), 32'd1);
    chk("dense_count", {29'd0, rot_count}, 32'd6);
    chk("dense_idle", {31'd0, busy}, 32'd0);
    chk("idle_step0", {26'd0, rot_i, rot_j, rot_col}, 32'b10_11_00);

    // All-zero targets, one of them -0.0
    fill_dense();
    mat[3][0] = 32'h0; mat[2][0] = 32'h0; mat[1][0] = 32'h8000_0000;
    mat[3][1] = 32'h0; mat[2][1] = 32'h0; mat[3][2] = 32'h8000_0000;
    run(1'b0, 1'b0, 12);
    chk("zero_nreq", 32'(nreq), 32'd0);
    chk("zero_done_cyc", 32'(done_cyc), 32'd7);
    chk("zero_count", {29'd0, rot_count}, 32'd0);

    // Partial skip; a denormal target must still be rotated
    fill_dense();
    mat[3][0] = 32'h0; mat[2][1] = 32'h0; mat[1][0] = 32'h0000_0001;
    run(1'b0, 1'b0, 20);
    chk("skip_nreq", 32'(nreq), 32'd4);
    chk("skip_req0", {26'd0, reqs[0]}, 32'b01_10_00);
    chk("skip_req1", {26'd0, reqs[1]}, 32'b00_01_00);
    chk("skip_req2", {26'd0, reqs[2]}, 32'b10_11_01);
    chk("skip_req3", {26'd0, reqs[3]}, 32'b10_11_10);
    chk("skip_done_cyc", 32'(done_cyc), 32'd15);
    chk("skip_count", {29'd0, rot_count}, 32'd4);

    // Backpressure on step 2 with stray rot_done pulses during ISSUE
    fill_dense();
    run(1'b1, 1'b0, 30);
    chk("bp_nreq", 32'(nreq), 32'd6);
    chk_dense_order("bp_order");
    chk("bp_done_cyc", 32'(done_cyc), 32'd24);
    chk("bp_count", {29'd0, rot_count}, 32'd6);

    // Start while busy (WAIT of step 3) and during DONE
    run(1'b0, 1'b1, 26);
    chk("sb_done_cnt", 32'(done_cnt), 32'd1);
    chk("sb_done_cyc", 32'(done_cyc), 32'd19);
    chk("sb_nreq", 32'(nreq), 32'd6);
    chk("sb_idle", {31'd0, busy}, 32'd0);
    chk("sb_count_hold", {29'd0, rot_count}, 32'd6);
    run(1'b0, 1'b0, 22);
    chk("sb_fresh_done", 32'(done_cyc), 32'd19);
    chk("sb_fresh_nreq", 32'(nreq), 32'd6);

    // Reset asserted during WAIT of step 4
    nreq = 0; pend = 0; done_cnt = 0;
    start = 1'b1;
    for (int k = 0; k < 40 && nreq < 5; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      rot_ready = 1'b1;
      rot_done = pend;
      pend = 0;
      if (rot_valid) begin
        nreq++;
        pend = 1;
      end
    end
    chk("rw_reached", 32'(nreq), 32'd5);
    @(posedge clock); #1;
    rot_done = 1'b0;
    chk("rw_in_wait", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_done", {31'd0, done}, 32'd0);
    chk("rw_valid", {31'd0, rot_valid}, 32'd0);
    chk("rw_count", {29'd0, rot_count}, 32'd0);
    chk("rw_step", {26'd0, rot_i, rot_j, rot_col}, 32'b10_11_00);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    chk("rw_no_done", 32'(done_cnt), 32'd0);
    chk("rw_idle", {31'd0, busy}, 32'd0);
    run(1'b0, 1'b0, 22);
    chk("rw_rerun_done", 32'(done_cyc), 32'd19);
    chk("rw_rerun_count", {29'd0, rot_count}, 32'd6);
    chk_dense_order("rw_rerun_order");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
